// File: rtl/sump_selftest_sequencer_if.sv
// UART transmit byte channel between the self-test sequencer and the TX path.
interface sump_selftest_sequencer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/sump_selftest_sequencer.sv
// SUMP self-test command sequencer: emits the bring-up command stream, enumerates
// channel-group disable masks and drains each internal-testmode capture with 0x7F bytes.
module sump_selftest_sequencer #(
  parameter int unsigned GROUPS      = 4,
  parameter logic [31:0] DIVIDER     = 32'h0000_0000,
  parameter logic [15:0] READ_COUNT  = 16'h0004,
  parameter logic [15:0] DELAY_COUNT = 16'h0004,
  parameter logic [31:0] FLAGS_BASE  = 32'h0000_0800,
  parameter int unsigned TIMEOUT     = 1_000_000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             mode,
  input  logic                             dataReady,
  sump_selftest_sequencer_if.master        tx,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [7:0]                       test_idx,
  output logic [15:0]                      drain_cnt
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] PRE_RST = 4'd1;
  localparam logic [3:0] PRE_ID  = 4'd2;
  localparam logic [3:0] TRIG    = 4'd3;
  localparam logic [3:0] T_RST   = 4'd4;
  localparam logic [3:0] T_FLAGS = 4'd5;
  localparam logic [3:0] T_DIV   = 4'd6;
  localparam logic [3:0] T_CNT   = 4'd7;
  localparam logic [3:0] T_RUN   = 4'd8;
  localparam logic [3:0] WAIT    = 4'd9;
  localparam logic [3:0] DRAIN   = 4'd10;
  localparam logic [3:0] NEXT    = 4'd11;
  localparam logic [3:0] FIN     = 4'd12;

  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [3:0]        state;
  logic [2:0]        byte_idx;
  logic [1:0]        trig_sel;
  logic              in_pre;
  logic              mode_l;
  logic [GROUPS-1:0] e;
  logic [GROUPS-1:0] e_inc;
  logic [GROUPS-1:0] dis;
  logic [WAIT_W-1:0] wait_cnt;

  logic        long_cmd;
  logic [7:0]  op;
  logic [31:0] val;
  logic [31:0] trig_val;
  logic [7:0]  tx_byte;
  logic        accept;
  logic        last_byte;
  logic        keep;

  assign dis   = ~e;
  assign e_inc = e + GROUPS'(1);
  assign keep  = mode_l | ($countones(e_inc) == 1);

  always_comb begin
    case (trig_sel)
      2'd0:    trig_val = 32'h0000_00FF;
      2'd1:    trig_val = 32'h0000_0040;
      default: trig_val = 32'h0800_0000;
    endcase
  end

  // The five-byte reset burst is treated as a long command with opcode and value all zero.
  always_comb begin
    op       = '0;
    val      = '0;
    long_cmd = 1'b0;
    case (state)
      PRE_RST: long_cmd = 1'b1;
      PRE_ID:  op = 8'h02;
      TRIG: begin
        long_cmd = 1'b1;
        op       = 8'hC0 | {6'd0, trig_sel};
        val      = trig_val;
      end
      T_RST:   op = 8'h00;
      T_FLAGS: begin
        long_cmd = 1'b1;
        op       = 8'h82;
        val      = FLAGS_BASE | (32'(dis) << 2);
      end
      T_DIV: begin
        long_cmd = 1'b1;
        op       = 8'h80;
        val      = DIVIDER;
      end
      T_CNT: begin
        long_cmd = 1'b1;
        op       = 8'h81;
        val      = {DELAY_COUNT, READ_COUNT};
      end
      T_RUN:   op = 8'h01;
      DRAIN:   op = 8'h7F;
      default: ;
    endcase
  end

  always_comb begin
    case (byte_idx)
      3'd1:    tx_byte = val[7:0];
      3'd2:    tx_byte = val[15:8];
      3'd3:    tx_byte = val[23:16];
      3'd4:    tx_byte = val[31:24];
      default: tx_byte = op;
    endcase
  end

  assign tx.tx_data  = tx_byte;
  assign tx.tx_valid = (state == PRE_RST) || (state == PRE_ID) || (state == TRIG) ||
                       (state == T_RST) || (state == T_FLAGS) || (state == T_DIV) ||
                       (state == T_CNT) || (state == T_RUN) || (state == DRAIN);
  assign accept    = tx.tx_valid & tx.tx_ready;
  assign last_byte = !long_cmd || (byte_idx == 3'd4);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      byte_idx  <= '0;
      trig_sel  <= '0;
      in_pre    <= 1'b0;
      mode_l    <= 1'b0;
      e         <= '0;
      wait_cnt  <= '0;
      error     <= 1'b0;
      test_idx  <= '0;
      drain_cnt <= '0;
    end else begin
      if (accept) byte_idx <= last_byte ? 3'd0 : byte_idx + 3'd1;
      case (state)
        IDLE: if (start) begin
          state     <= PRE_RST;
          error     <= 1'b0;
          test_idx  <= 8'hFF;
          drain_cnt <= '0;
          in_pre    <= 1'b1;
          mode_l    <= mode;
          e         <= GROUPS'(1);
          trig_sel  <= '0;
        end
        PRE_RST: if (accept && last_byte) state <= PRE_ID;
        PRE_ID: if (accept) begin
          state    <= WAIT;
          wait_cnt <= '0;
        end
        TRIG: if (accept && last_byte) begin
          if (trig_sel == 2'd2) begin
            state     <= T_RST;
            in_pre    <= 1'b0;
            test_idx  <= '0;
            drain_cnt <= '0;
          end else begin
            trig_sel <= trig_sel + 2'd1;
          end
        end
        T_RST:   if (accept) state <= T_FLAGS;
        T_FLAGS: if (accept && last_byte) state <= T_DIV;
        T_DIV:   if (accept && last_byte) state <= T_CNT;
        T_CNT:   if (accept && last_byte) state <= T_RUN;
        T_RUN: if (accept) begin
          state    <= WAIT;
          wait_cnt <= '0;
        end
        WAIT: begin
          if (dataReady) begin
            state <= DRAIN;
          end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            state <= IDLE;
            error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        // dataReady is re-sampled on the accepting edge, so a byte pending when it falls still completes.
        DRAIN: if (accept) begin
          drain_cnt <= drain_cnt + 16'd1;
          if (!dataReady) state <= in_pre ? TRIG : NEXT;
        end
        NEXT: begin
          if (&e_inc) begin
            state <= FIN;
          end else begin
            e <= e_inc;
            if (keep) begin
              state     <= T_RST;
              test_idx  <= test_idx + 8'd1;
              drain_cnt <= '0;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sump_selftest_sequencer.sv
// Scoreboard bench for sump_selftest_sequencer: expected byte stream from a list-based model,
// checked by an independent monitor against a randomised TX sink and dataReady responder.
module tb_sump_selftest_sequencer;

  localparam logic [31:0] FLAGS_BASE = 32'h0000_0800;
  localparam logic [31:0] DIVIDER    = 32'h0000_0000;
  localparam logic [31:0] CNT_VAL    = 32'h0004_0004;

  typedef struct {
    logic [7:0]  b;
    logic [7:0]  idx;
    int unsigned dr;
    int unsigned kind;  // 0 command byte, 1 run/id byte, 2 drain byte
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_req, mode, dataReady, tx_ready, sel;
  logic start4, start2;
  logic busy4, done4, error4, busy2, done2, error2;
  logic [7:0]  idx4, idx2;
  logic [15:0] drain4, drain2;

  sump_selftest_sequencer_if if4 ();
  sump_selftest_sequencer_if if2 ();
  assign if4.tx_ready = tx_ready;
  assign if2.tx_ready = tx_ready;
  assign start4 = start_req & ~sel;
  assign start2 = start_req & sel;

  sump_selftest_sequencer #(.GROUPS(4), .TIMEOUT(100)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode), .dataReady(dataReady),
    .tx(if4), .busy(busy4), .done(done4), .error(error4),
    .test_idx(idx4), .drain_cnt(drain4)
  );

  sump_selftest_sequencer #(.GROUPS(2), .TIMEOUT(100)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode), .dataReady(dataReady),
    .tx(if2), .busy(busy2), .done(done2), .error(error2),
    .test_idx(idx2), .drain_cnt(drain2)
  );

  logic        m_valid, m_busy, m_done, m_error;
  logic [7:0]  m_data, m_idx;
  logic [15:0] m_drain;
  assign m_valid = sel ? if2.tx_valid : if4.tx_valid;
  assign m_data  = sel ? if2.tx_data  : if4.tx_data;
  assign m_busy  = sel ? busy2  : busy4;
  assign m_done  = sel ? done2  : done4;
  assign m_error = sel ? error2 : error4;
  assign m_idx   = sel ? idx2   : idx4;
  assign m_drain = sel ? drain2 : drain4;

  int unsigned checks = 0, errors = 0;
  exp_t        exp_q[$];
  int unsigned n_list[$];
  int unsigned run_cnt = 0, ff_cnt = 0, done_cnt = 0, run_base = 0, done_base = 0;
  bit          rdy_random = 0, resp_en = 1, fixed_n = 1, fixed_delay = 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic push(input logic [7:0] b, input logic [7:0] idx, input int unsigned dr,
                      input int unsigned kind);
    exp_t x;
    x.b = b; x.idx = idx; x.dr = dr; x.kind = kind;
    exp_q.push_back(x);
  endtask

  task automatic push_long(input logic [7:0] op, input logic [31:0] v, input logic [7:0] idx,
                           input int unsigned dr);
    push(op, idx, dr, 0);
    for (int unsigned i = 0; i < 4; i++) push(8'(v >> (8 * i)), idx, dr, 0);
  endtask

  function automatic int unsigned pick_n();
    return fixed_n ? 3 : $urandom_range(2, 4);
  endfunction

  // Reference stream: preamble, then every kept enable mask in ascending order.
  task automatic build_run(input int unsigned groups, input bit m, input bit to_only,
                           output int unsigned ntests, output int unsigned last_n);
    int unsigned n, t, mask, flags;
    n_list.delete();
    ntests = 0; last_n = 0; t = 0;
    for (int unsigned i = 0; i < 5; i++) push(8'h00, 8'hFF, 0, 0);
    push(8'h02, 8'hFF, 0, 1);
    if (to_only) return;
    n = pick_n(); n_list.push_back(n);
    for (int unsigned k = 0; k < n; k++) push(8'h7F, 8'hFF, k, 2);
    push_long(8'hC0, 32'h0000_00FF, 8'hFF, n);
    push_long(8'hC1, 32'h0000_0040, 8'hFF, n);
    push_long(8'hC2, 32'h0800_0000, 8'hFF, n);
    mask = (1 << groups) - 1;
    for (int unsigned e = 1; e < mask; e++) begin
      if (!m && $countones(e) != 1) continue;
      flags = FLAGS_BASE | (((~e) & mask) << 2);
      push(8'h00, 8'(t), 0, 0);
      push_long(8'h82, flags, 8'(t), 0);
      push_long(8'h80, DIVIDER, 8'(t), 0);
      push_long(8'h81, CNT_VAL, 8'(t), 0);
      push(8'h01, 8'(t), 0, 1);
      n = pick_n(); n_list.push_back(n);
      for (int unsigned k = 0; k < n; k++) push(8'h7F, 8'(t), k, 2);
      t++;
      last_n = n;
    end
    ntests = t;
  endtask

  // TX sink and dataReady responder; changes inputs only on the falling edge.
  initial begin : driver
    int unsigned delay, last_run, nreq, idx;
    bit armed, raised;
    tx_ready = 1'b0; dataReady = 1'b0;
    delay = 0; last_run = 0; nreq = 2; armed = 0; raised = 0;
    forever begin
      @(negedge clk);
      tx_ready = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
      if (run_cnt != last_run) begin
        last_run = run_cnt;
        armed    = 1; raised = 0;
        delay    = fixed_delay ? 10 : $urandom_range(0, 12);
        idx      = run_cnt - run_base - 1;
        nreq     = (idx < n_list.size()) ? n_list[idx] : 2;
      end else if (armed && !raised) begin
        if (delay == 0) raised = 1;
        else delay--;
      end
      dataReady = resp_en && raised && (ff_cnt < nreq - 1);
    end
  end

  initial begin : monitor
    bit         stall, prev_rst;
    logic [7:0] stall_data;
    exp_t       x;
    stall = 0; prev_rst = 0; stall_data = '0;
    forever begin
      @(negedge clk);
      #2;
      if (stall && !prev_rst) begin
        check("hold_valid", m_valid, 1'b1);
        check("hold_data", m_data, stall_data);
      end
      if (m_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_byte got %0h expected none", m_data);
        end else begin
          x = exp_q.pop_front();
          check("tx_data", m_data, x.b);
          check("test_idx", m_idx, x.idx);
          check("drain_cnt", m_drain, x.dr);
          if (x.kind == 1) begin run_cnt++; ff_cnt = 0; end
          else if (x.kind == 2) ff_cnt++;
        end
      end
      if (m_done) done_cnt++;
      stall      = m_valid && !tx_ready;
      stall_data = m_data;
      prev_rst   = rst;
    end
  end

  task automatic start_run(input int unsigned groups, input bit m, input bit to_only,
                           output int unsigned ntests, output int unsigned last_n);
    build_run(groups, m, to_only, ntests, last_n);
    run_base  = run_cnt;
    done_base = done_cnt;
    @(negedge clk); #1;
    mode = m; start_req = 1'b1;
    @(negedge clk); #1;
    start_req = 1'b0;
    check("start_busy", m_busy, 1'b1);
    check("start_valid", m_valid, 1'b1);
    check("start_error", m_error, 1'b0);
    check("start_idx", m_idx, 8'hFF);
    mode = ~m;
  endtask

  task automatic finish_run(input int unsigned ntests, input int unsigned last_n);
    bit ok = 0;
    for (int unsigned c = 0; c < 20000; c++) begin
      @(negedge clk); #1;
      if (done_cnt != done_base) begin ok = 1; break; end
      start_req = (c == 40);
    end
    start_req = 1'b0;
    check("done_seen", ok, 1'b1);
    check("end_busy", m_busy, 1'b0);
    check("end_idx", m_idx, 8'(ntests - 1));
    check("end_drain", m_drain, 16'(last_n));
    check("queue_left", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    #1;
    check("done_pulses", done_cnt - done_base, 1);
  endtask

  task automatic full_run(input bit s, input int unsigned groups, input bit m,
                          input int unsigned want_tests);
    int unsigned nt, ln;
    sel = s;
    start_run(groups, m, 1'b0, nt, ln);
    check("model_tests", nt, want_tests);
    finish_run(nt, ln);
  endtask

  initial begin : main
    int unsigned nt, ln;
    bit found;
    rst = 1'b1; start_req = 1'b0; mode = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", if4.tx_valid, 1'b0);
    check("rst_data", if4.tx_data, 8'h00);
    check("rst_busy", busy4, 1'b0);
    check("rst_done", done4, 1'b0);
    check("rst_error", error4, 1'b0);
    check("rst_idx", idx4, 8'h00);
    check("rst_drain", drain4, 16'h0000);
    check("rst_valid2", if2.tx_valid, 1'b0);
    rst = 1'b0;

    rdy_random = 0; fixed_n = 1; fixed_delay = 1;
    full_run(1'b0, 4, 1'b0, 4);

    rdy_random = 1; fixed_n = 0; fixed_delay = 0;
    full_run(1'b0, 4, 1'b1, 14);

    rdy_random = 0; fixed_n = 1; fixed_delay = 1;
    full_run(1'b1, 2, 1'b1, 2);

    rdy_random = 1;
    full_run(1'b0, 4, 1'b0, 4);

    // Timeout: responder silent after the ID byte.
    rdy_random = 0; resp_en = 0; sel = 1'b0;
    start_run(4, 1'b0, 1'b1, nt, ln);
    found = 0;
    for (int unsigned c = 0; c < 50; c++) begin
      if (m_valid && tx_ready && m_data == 8'h02) begin found = 1; break; end
      @(negedge clk); #1;
    end
    check("id_seen", found, 1'b1);
    repeat (100) @(negedge clk);
    #1;
    check("to_error_early", m_error, 1'b0);
    check("to_busy_early", m_busy, 1'b1);
    @(negedge clk); #1;
    check("to_error", m_error, 1'b1);
    check("to_idx", m_idx, 8'hFF);
    check("to_busy", m_busy, 1'b0);
    check("to_valid", m_valid, 1'b0);
    check("to_queue", exp_q.size(), 0);

    // Mid-run reset inside the flags command of test 2, then a full replay.
    resp_en = 1;
    start_run(4, 1'b0, 1'b0, nt, ln);
    found = 0;
    for (int unsigned c = 0; c < 2000; c++) begin
      @(negedge clk); #1;
      if (m_valid && m_idx == 8'd2 && m_data == 8'h82) begin found = 1; break; end
    end
    check("flags2_seen", found, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk); #1;
    check("mrst_valid", m_valid, 1'b0);
    check("mrst_data", m_data, 8'h00);
    check("mrst_busy", m_busy, 1'b0);
    check("mrst_done", m_done, 1'b0);
    check("mrst_error", m_error, 1'b0);
    check("mrst_idx", m_idx, 8'h00);
    check("mrst_drain", m_drain, 16'h0000);
    rst = 1'b0;
    exp_q.delete();
    full_run(1'b0, 4, 1'b0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
